// File: rtl/inst_align_unit_pkg.sv
// Shared constants for the fetch-side aligner and decomp_unit.
// Halfword/word widths and the RVC detection pattern.
package inst_align_unit_pkg;

  localparam int HW_W = 16;
  localparam int WORD_W = 32;
  localparam logic [1:0] RVC_UNCOMP = 2'b11;

  function automatic logic is_rvc(input logic [1:0] low);
    return low != RVC_UNCOMP;
  endfunction

endpackage

// File: rtl/inst_align_unit_if.sv
// Memory fetch port and decode-side delivery port of the aligner.
// master = aligner view, slave = memory/decode environment view.
interface inst_align_unit_if;
  import inst_align_unit_pkg::*;

  logic              mem_req_o;
  logic [WORD_W-1:0] mem_addr_o;
  logic              mem_valid_i;
  logic [WORD_W-1:0] mem_word_i;
  logic              flush_i;
  logic [WORD_W-1:0] flush_pc_i;
  logic              inst_valid_o;
  logic              out_ready_i;
  logic [WORD_W-1:0] inst_o;
  logic              inst_compressed_o;
  logic [WORD_W-1:0] inst_pc_o;

  modport master (
    output mem_req_o, mem_addr_o,
    output inst_valid_o, inst_o,
    output inst_compressed_o, inst_pc_o,
    input  mem_valid_i, mem_word_i,
    input  flush_i, flush_pc_i,
    input  out_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    input  inst_valid_o, inst_o,
    input  inst_compressed_o, inst_pc_o,
    output mem_valid_i, mem_word_i,
    output flush_i, flush_pc_i,
    output out_ready_i
  );

endinterface

// File: rtl/inst_align_unit_hw_queue.sv
// 3-entry halfword FIFO: pop 0/1/2 then push 0/1/2 in one cycle.
// Ports: clk, rst, clr, pop_n, push_n, push_hw0/1 in; q0, q1, cnt out.
module inst_align_unit_hw_queue
  import inst_align_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [1:0]      pop_n,
  input  logic [1:0]      push_n,
  input  logic [HW_W-1:0] push_hw0,
  input  logic [HW_W-1:0] push_hw1,
  output logic [HW_W-1:0] q0,
  output logic [HW_W-1:0] q1,
  output logic [1:0]      cnt
);

  logic [HW_W-1:0] slot [3];
  logic [HW_W-1:0] slot_nxt [3];
  logic [1:0]      base;
  logic [1:0]      cnt_nxt;

  always_comb begin
    base = cnt - pop_n;
    slot_nxt = slot;
    case (pop_n)
      2'd1: begin
        slot_nxt[0] = slot[1];
        slot_nxt[1] = slot[2];
      end
      2'd2: slot_nxt[0] = slot[2];
      default: ;
    endcase
    // pushes land behind whatever survived the pop
    for (int i = 0; i < 3; i++) begin
      if (push_n != 2'd0 && i == int'(base))
        slot_nxt[i] = push_hw0;
      if (push_n == 2'd2 && i == int'(base) + 1)
        slot_nxt[i] = push_hw1;
    end
    cnt_nxt = clr ? 2'd0 : base + push_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      slot <= '{default: '0};
    end else begin
      cnt  <= cnt_nxt;
      slot <= slot_nxt;
    end
  end

  assign q0 = slot[0];
  assign q1 = slot[1];

endmodule

// File: rtl/inst_align_unit.sv
// Fetch aligner: word fetches in, one RVC or 32-bit instruction out.
// Ports: clk_i, rst_i (sync, active high), bus (master modport).
module inst_align_unit
  import inst_align_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  inst_align_unit_if.master bus
);

  logic [31:0]     pc;
  logic [31:0]     fa;
  logic            pend;
  logic            drop;
  logic            skip;

  logic [HW_W-1:0] q0;
  logic [HW_W-1:0] q1;
  logic [1:0]      cnt;
  logic [1:0]      cnt_post;
  logic [1:0]      pop_n;
  logic [1:0]      push_n;
  logic [HW_W-1:0] push_hw0;
  logic [HW_W-1:0] push_hw1;

  logic            q0_rvc;
  logic            valid;
  logic            xfer;
  logic            req;
  logic            resp;

  assign q0_rvc = is_rvc(q0[1:0]);
  assign valid  = (cnt >= 2'd1 && q0_rvc)
               || cnt >= 2'd2;
  assign xfer   = valid & bus.out_ready_i
               & ~bus.flush_i;
  assign pop_n  = !xfer  ? 2'd0 :
                  q0_rvc ? 2'd1 : 2'd2;
  assign cnt_post = cnt - pop_n;

  // one request in flight keeps cnt_post+2 <= 3
  assign req  = ~rst_i & ~bus.flush_i & ~pend
              & ~drop & (cnt_post <= 2'd1);
  assign resp = bus.mem_valid_i & pend;

  always_comb begin
    push_n   = 2'd0;
    push_hw0 = bus.mem_word_i[15:0];
    push_hw1 = bus.mem_word_i[31:16];
    if (resp & ~drop & ~bus.flush_i) begin
      if (skip) begin
        push_n   = 2'd1;
        push_hw0 = bus.mem_word_i[31:16];
      end else begin
        push_n   = 2'd2;
      end
    end
  end

  inst_align_unit_hw_queue u_hw_queue (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr      (bus.flush_i),
    .pop_n    (pop_n),
    .push_n   (push_n),
    .push_hw0 (push_hw0),
    .push_hw1 (push_hw1),
    .q0       (q0),
    .q1       (q1),
    .cnt      (cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc   <= RESET_PC;
      fa   <= {RESET_PC[31:2], 2'b00};
      pend <= 1'b0;
      drop <= 1'b0;
      skip <= RESET_PC[1];
    end else if (bus.flush_i) begin
      pc   <= bus.flush_pc_i;
      fa   <= {bus.flush_pc_i[31:2], 2'b00};
      skip <= bus.flush_pc_i[1];
      // a still-missing response must be swallowed later
      pend <= pend & ~bus.mem_valid_i;
      drop <= pend & ~bus.mem_valid_i;
    end else begin
      if (xfer)
        pc <= pc + (q0_rvc ? 32'd2 : 32'd4);
      if (req) begin
        pend <= 1'b1;
        fa   <= fa + 32'd4;
      end
      if (resp) begin
        pend <= 1'b0;
        if (drop)
          drop <= 1'b0;
        else if (skip)
          skip <= 1'b0;
      end
    end
  end

  assign bus.mem_req_o  = req;
  assign bus.mem_addr_o = fa;
  assign bus.inst_valid_o = valid;
  assign bus.inst_o =
    !valid ? 32'h0 :
    q0_rvc ? {16'h0, q0} : {q1, q0};
  assign bus.inst_compressed_o = valid & q0_rvc;
  assign bus.inst_pc_o = pc;

endmodule

// File: tb/tb_inst_align_unit.sv
// Bench for inst_align_unit: directed scenarios plus random
// latency/stall/flush traffic against an instruction-stream model.
module tb_inst_align_unit;
  import inst_align_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_align_unit_if bus ();

  inst_align_unit #(.RESET_PC(32'h0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ntr = 0;
  int lat_min = 1;
  int lat_max = 1;

  logic [31:0] mem [int unsigned];
  logic [31:0] pq_addr [$];
  int          pq_due [$];
  logic [31:0] tr_inst [$];
  logic [31:0] tr_pc [$];
  int          tr_cyc [$];

  logic [31:0] exp_pc;
  logic        p_hold;
  logic        s_req, s_valid, s_comp;
  logic [31:0] s_addr, s_inst, s_pc;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] x;
    if (mem.exists(a)) return mem[a];
    x = (a ^ 32'h5bd1e995) * 32'h9e3779b1;
    return x ^ (x >> 13);
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.mem_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    pq_addr.delete();
    pq_due.delete();
    @(negedge clk);
    #1;
    chk1("rst_req", bus.mem_req_o, 1'b0);
    chk1("rst_valid", bus.inst_valid_o, 1'b0);
    chk("rst_inst", bus.inst_o, 32'h0);
    chk1("rst_comp", bus.inst_compressed_o, 1'b0);
    chk("rst_pc", bus.inst_pc_o, 32'h0);
    exp_pc = 32'h0;
    p_hold = 1'b0;
    tr_inst.delete();
    tr_pc.delete();
    tr_cyc.delete();
  endtask

  task automatic step(input logic fl, input logic [31:0] fpc,
                      input logic rdy);
    logic        mv;
    logic [31:0] w, ei;
    logic [15:0] h;
    logic        hc;
    int          nout;
    @(negedge clk);
    nout = pq_due.size();
    mv = 1'b0;
    w = $urandom;
    if (nout > 0 && pq_due[0] <= cyc) begin
      mv = 1'b1;
      w = word_at(pq_addr[0]);
      void'(pq_due.pop_front());
      void'(pq_addr.pop_front());
    end
    rst = 1'b0;
    bus.mem_valid_i = mv;
    bus.mem_word_i = w;
    bus.flush_i = fl;
    bus.flush_pc_i = fpc;
    bus.out_ready_i = rdy;
    #1;
    s_req = bus.mem_req_o;
    s_addr = bus.mem_addr_o;
    s_valid = bus.inst_valid_o;
    s_inst = bus.inst_o;
    s_pc = bus.inst_pc_o;
    s_comp = bus.inst_compressed_o;
    if (p_hold) chk1("hold_valid", s_valid, 1'b1);
    if (s_valid) begin
      h = half_at(exp_pc);
      hc = h[1:0] != 2'b11;
      ei = hc ? {16'h0, h} : {half_at(exp_pc + 32'd2), h};
      chk("inst", s_inst, ei);
      chk("pc", s_pc, exp_pc);
      chk1("comp", s_comp, hc);
      if (rdy && !fl) begin
        tr_inst.push_back(s_inst);
        tr_pc.push_back(s_pc);
        tr_cyc.push_back(cyc);
        ntr++;
        exp_pc = exp_pc + (hc ? 32'd2 : 32'd4);
      end
    end
    if (s_req) begin
      chk("req_single", 32'(nout), 32'd0);
      chk("req_align", {30'b0, s_addr[1:0]}, 32'd0);
      pq_addr.push_back(s_addr);
      pq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (fl) exp_pc = fpc;
    p_hold = s_valid & ~rdy & ~fl;
    cyc++;
  endtask

  initial begin
    bus.flush_i = 1'b0;
    bus.flush_pc_i = 32'h0;
    bus.mem_valid_i = 1'b0;
    bus.mem_word_i = 32'h0;
    bus.out_ready_i = 1'b0;
    p_hold = 1'b0;
    exp_pc = 32'h0;

    // aligned 32-bit
    mem[32'h0] = 32'h00130093;
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    chk1("t1_req", s_req, 1'b1);
    chk("t1_addr", s_addr, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk1("t1_early", s_valid, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk1("t1_valid", s_valid, 1'b1);
    chk("t1_inst", s_inst, 32'h00130093);
    chk1("t1_comp", s_comp, 1'b0);
    chk("t1_pc", s_pc, 32'h0);

    // two compressed in one word
    mem[32'h0] = 32'h42120001;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    chk("t2_count", 32'(tr_pc.size()), 32'd2);
    if (tr_pc.size() >= 2) begin
      chk("t2_inst0", tr_inst[0], 32'h00000001);
      chk("t2_pc0", tr_pc[0], 32'h0);
      chk("t2_inst1", tr_inst[1], 32'h00004212);
      chk("t2_pc1", tr_pc[1], 32'h2);
      chk("t2_consec", 32'(tr_cyc[1] - tr_cyc[0]), 32'd1);
    end

    // straddling, then a 4-cycle stall with a full queue
    mem[32'h0] = 32'h00930001;
    mem[32'h4] = 32'h00010013;
    mem[32'h100] = 32'h4212ABCD;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b0);
      chk1("stall_req", s_req, 1'b0);
      chk1("stall_valid", s_valid, 1'b1);
      chk("stall_pc", s_pc, 32'h2);
    end
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1);
    chk("t3_count", 32'(tr_pc.size()), 32'd3);
    if (tr_pc.size() >= 3) begin
      chk("t3_inst0", tr_inst[0], 32'h00000001);
      chk("t3_pc0", tr_pc[0], 32'h0);
      chk("t3_inst1", tr_inst[1], 32'h00130093);
      chk("t3_pc1", tr_pc[1], 32'h2);
      chk("t3_inst2", tr_inst[2], 32'h00000001);
      chk("t3_pc2", tr_pc[2], 32'h6);
    end

    // misaligned redirect, nothing outstanding
    step(1'b1, 32'h102, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk1("t4_req", s_req, 1'b1);
    chk("t4_addr", s_addr, 32'h100);
    step(1'b0, 32'h0, 1'b1);
    chk1("t4_early", s_valid, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk1("t4_valid", s_valid, 1'b1);
    chk("t4_inst", s_inst, 32'h00004212);
    chk("t4_pc", s_pc, 32'h102);

    // flush with a request outstanding, 3-cycle memory
    mem[32'h0] = 32'h00010001;
    mem[32'h200] = 32'h00130093;
    lat_min = 3;
    lat_max = 3;
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    chk1("t6_req0", s_req, 1'b1);
    chk("t6_addr0", s_addr, 32'h0);
    step(1'b1, 32'h200, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk1("t6_noreq", s_req, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk1("t6_drain", s_req, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk1("t6_req1", s_req, 1'b1);
    chk("t6_addr1", s_addr, 32'h200);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    chk1("t6_valid", s_valid, 1'b1);
    chk("t6_pc", s_pc, 32'h200);
    chk("t6_inst", s_inst, 32'h00130093);

    // random latency, stalls, redirects and resets
    lat_min = 1;
    lat_max = 3;
    ntr = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 39) == 0,
             32'($urandom_range(0, 511)) << 1,
             $urandom_range(0, 99) < 75);
      end
    end
    chk1("progress", ntr >= 200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_align_unit.md
# inst_align_unit

Fetch-side instruction aligner between instruction memory and the decode stage. It fetches word-aligned 32-bit memory words and buffers halfwords. It delivers one complete instruction per handshake, either a 16-bit RVC or a full 32-bit instruction, including 32-bit instructions that straddle a word boundary, together with its PC. Compressed outputs feed `decomp_unit` (`inst_o[15:0]` → `comp_inst_i`); full-width outputs bypass it.

## Interface
- `RESET_PC`, 32'h0000_0000: PC of the first instruction after reset; must be halfword-aligned.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `mem_req_o`  out  1  fetch request; memory always accepts it in the same cycle.
- `mem_addr_o`  out  32  fetch address; bits [1:0] always 0.
- `mem_valid_i`  in  1  response strobe; at least 1 cycle after its request.
- `mem_word_i`  in  32  response data, little-endian; low halfword at the lower address.
- `flush_i`  in  1  redirect (branch, jump or trap).
- `flush_pc_i`  in  32  redirect target; halfword-aligned.
- `inst_valid_o`  out  1  an instruction is presented.
- `out_ready_i`  in  1  decode accepts; transfer = `inst_valid_o & out_ready_i`.
- `inst_o`  out  32  instruction; compressed instructions are zero-extended (`{16'h0, hw}`).
- `inst_compressed_o`  out  1  `inst_o[1:0] != 2'b11`.
- `inst_pc_o`  out  32  PC of the presented instruction.

## Operation
- **State**
  - Halfword queue of 3 entries: `q0` is the oldest, `cnt` ranges 0..3.
  - `pc`: PC of `q0`.
  - `fa`: next fetch address.
  - `pend`: one request outstanding.
  - `drop`: discard the outstanding response.
  - `skip`: discard the low halfword of the next accepted word.
- **Presentation.** Combinational from registered state.
  - Valid when (`cnt>=1` and `q0[1:0]!=2'b11`) or `cnt>=2`.
  - 32-bit form: `inst_o = {q1, q0}`.
  - `inst_pc_o = pc`.
- **Consume.** On a transfer, pop 1 halfword (compressed) or 2 halfwords (32-bit); `pc += 2` or `pc += 4`.
- **Fetch.** `mem_req_o = !rst_i & !flush_i & !pend & (cnt <= 1)`, evaluated on post-consume `cnt`.
  - On request: `pend <= 1`, `fa += 4`.
  - At most one request is outstanding. This bounds the queue at 3 entries; no overflow is possible.
- **Response.** On `mem_valid_i & pend`:
  - `pend <= 0`.
  - If `drop`: clear `drop`; nothing is enqueued.
  - Else if `skip`: enqueue only the high halfword; clear `skip`.
  - Else: enqueue the low halfword, then the high halfword.
  - Pop and push in the same cycle are applied pop-first.
  - `mem_valid_i` without `pend` is ignored.
- **Flush.** Highest priority; overrides any transfer and any response in that cycle.
  - `cnt <= 0`, `pc <= flush_pc_i`, `fa <= {flush_pc_i[31:2], 2'b00}`, `skip <= flush_pc_i[1]`.
  - If `pend`, or a response arrives that same cycle, the old response is dropped: `drop <= pend & !mem_valid_i`.
  - No request is issued in the flush cycle, nor while `drop` is set.
- **Reset.**
  - Outputs: `mem_req_o=0`, `inst_valid_o=0`, `inst_o=0`, `inst_compressed_o=0`, `inst_pc_o=RESET_PC`.
  - State: `cnt=0`, `pend=drop=0`, `pc=RESET_PC`, `fa={RESET_PC[31:2], 2'b00}`, `skip=RESET_PC[1]`.
  - Reset mid-operation abandons any outstanding response; `mem_valid_i` after reset without `pend` is ignored.
- **Control.** States: EMPTY (`cnt=0`), PARTIAL (only a 32-bit low half buffered), READY (`inst_valid_o`), each crossed with WAIT (`pend`) or DRAIN (`pend & drop`).

## Timing
- First request is issued in the first cycle after `rst_i` deasserts.
- With a 1-cycle memory response, the first `inst_valid_o` appears 2 cycles after the request.
- Sustained throughput with 1-cycle memory:
  - Compressed stream: 1 instruction/cycle.
  - 32-bit stream: 1 instruction per 2 cycles.
- Redirect-to-valid: 3 cycles with 1-cycle memory and no outstanding request.
- While stalled (`out_ready_i=0`), `inst_o`, `inst_pc_o` and `inst_compressed_o` hold stable.

## Structure
- Shared defines header: RVC detection constant (`2'b11` = uncompressed) and halfword/word width constants, shared with `decomp_unit`.
- One natural sub-module: `hw_queue`, the 3-entry halfword FIFO with pop-1/pop-2/push-1/push-2 and a count output. Fetch control and PC tracking stay in `inst_align_unit`.

## Test plan
- **Aligned 32-bit.**
  - Stimulus: `RESET_PC=0`, word@0 = `32'h00130093`, 1-cycle memory.
  - Required: `inst_o=32'h00130093`, `inst_compressed_o=0`, `inst_pc_o=0`, two cycles after the first request.
- **Two compressed in one word.**
  - Stimulus: word@0 = `32'h42120001`.
  - Required: `inst_o=32'h00000001` at pc 0, then `inst_o=32'h00004212` at pc 2, on consecutive cycles.
- **Straddling.**
  - Stimulus: word@0 = `32'h00930001`, word@4 = `32'h00010013`.
  - Required: c.nop at pc 0, `32'h00130093` at pc 2, c.nop at pc 6.
- **Misaligned redirect.**
  - Stimulus: `flush_i` with `flush_pc_i=32'h102`, word@0x100 = `32'h4212ABCD`.
  - Required: `mem_addr_o=32'h100`; first output `32'h00004212` at pc `32'h102`; `ABCD` is never presented.
- **Stall.**
  - Stimulus: `out_ready_i=0` for 4 cycles with `cnt=3`.
  - Required: outputs stable throughout; `mem_req_o=0`; no lost or duplicated instruction after release.
- **Flush with request outstanding.**
  - Stimulus: 3-cycle memory; flush to `32'h200` one cycle after a request to `32'h0`.
  - Required: the stale response is dropped; the next request goes to `32'h200`; first output pc is `32'h200`.
